// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bus between the display write register and bin_to_bcd_seq.
// master = upstream producer/display side, slave = the converter.
interface bin_to_bcd_seq_if #(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned OUT_DIGITS = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_WIDTH-1:0]     bin_in;
  logic                    busy;
  logic                    done;
  logic [4*OUT_DIGITS-1:0] bcd_out;
  logic                    overflow;

  modport master (
    output in_valid, bin_in,
    input  in_ready, busy, done, bcd_out, overflow
  );

  modport slave (
    input  in_valid, bin_in,
    output in_ready, busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter, one input bit per clock.
// Optional macro SATURATE_DISPLAY_EN: on overflow, bcd_out shows all 9s instead of value mod 10^N.
module bin_to_bcd_seq #(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned BCD_DIGITS = 10,
  parameter int unsigned OUT_DIGITS = 8
) (
  input logic              clk,
  input logic              reset,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int unsigned AccW = 4 * BCD_DIGITS;
  localparam int unsigned OutW = 4 * OUT_DIGITS;
  localparam int unsigned CntW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(IN_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IN_WIDTH-1:0] sr_q, sr_d;
  logic [AccW-1:0]     acc_q, acc_d, acc_adj;
  logic [OutW-1:0]     bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                in_ready, busy, accept, ovf_now;

  assign accept = bus.in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StShift;
      StShift: if (cnt_q == LastCnt) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == StIdle);
    busy     = (state_q != StIdle);
  end

  // Add 3 to every digit >= 5, all digits in parallel with no inter-digit carry
  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  assign ovf_now = |(acc_q >> OutW);

  always_comb begin
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    acc_d  = acc_q;
    bcd_d  = bcd_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sr_d  = bus.bin_in;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      StShift: begin
        {acc_d, sr_d} = {acc_adj, sr_q} << 1;
        cnt_d         = cnt_q + 1'b1;
      end
      StDone: begin
`ifdef SATURATE_DISPLAY_EN
        bcd_d = ovf_now ? {OUT_DIGITS{4'h9}} : acc_q[OutW-1:0];
`else
        bcd_d = acc_q[OutW-1:0];
`endif
        ovf_d  = ovf_now;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      acc_q  <= '0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
      acc_q  <= acc_d;
      bcd_q  <= bcd_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule
